cdb_arbiter: RTL and testbench

- Shares the single Common Data Bus broadcast slot between N functional-unit requesters (ALU, multiplier, load, branch) that complete out of order.
- Each cycle it picks at most one requesting unit by round-robin and issues a one-cycle grant pulse to it.
- It drives a registered broadcast_valid/broadcast_tag pair straight into the CDB register stage, which then wakes up issue-queue entries.

---
 rtl/cdb_arbiter.sv | 125 ++++++++++++
 tb/tb_cdb_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the single Common Data Bus slot.
//   Picks at most one requesting functional unit per cycle (one-hot grant),
//   registers the winner's tag/index as the next cycle's broadcast, and
//   exposes the round-robin pointer for debug.
// Optional build macro: CDB_PRIO0_EN -- unit 0 (load unit) gets strict
//   priority over the round-robin units and never moves the pointer.
//
// Handshake: a unit holds req_valid[i]/req_tag[i] stable until it sees
//   grant[i]=1 at a rising edge, and consumes its request on that edge.
//   grant is never raised while cdb_stall, flush or reset is asserted, so a
//   stalled request simply stays pending.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  input  logic                     cdb_stall,
  input  logic                     flush,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     broadcast_valid,
  output logic [TAG_W-1:0]         broadcast_tag,
  output logic [2:0]               broadcast_src,
  output logic [2:0]               rr_ptr
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_REQ - 1);

  logic                 r_bcast_valid;
  logic [TAG_W-1:0]     r_bcast_tag;
  logic [2:0]           r_bcast_src;
  logic [2:0]           r_rr_ptr;

  logic                 w_block;
  logic [NUM_REQ-1:0]   w_req_rot;
  logic [NUM_REQ-1:0]   w_first_rot;
  logic [2*NUM_REQ-1:0] w_gnt_dbl;
  logic [NUM_REQ-1:0]   w_rr_grant;
  logic [NUM_REQ-1:0]   w_sel;
  logic                 w_upd_ptr;
  logic [NUM_REQ-1:0]   w_grant;
  logic                 w_any;
  logic [2:0]           w_win;
  logic [TAG_W-1:0]     w_win_tag;
  logic [2:0]           w_next_ptr;

  // Flush has priority over stall and requests; both simply suppress the grant.
  assign w_block = ~reset | cdb_stall | flush;

  // Rotate requests so that the unit at rr_ptr sits at bit 0.
  assign w_req_rot = NUM_REQ'({req_valid, req_valid} >> r_rr_ptr);

  // Find the lowest set bit of the rotated request vector.
  always_comb begin
    w_first_rot = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_req_rot[k]) begin
        w_first_rot    = '0;
        w_first_rot[k] = 1'b1;
      end
    end
  end

  // Rotate the one-hot winner back into unit numbering.
  assign w_gnt_dbl  = {{NUM_REQ{1'b0}}, w_first_rot} << r_rr_ptr;
  assign w_rr_grant = w_gnt_dbl[NUM_REQ-1:0] | w_gnt_dbl[2*NUM_REQ-1:NUM_REQ];

  // Select between the round-robin winner and the optional unit-0 priority.
  always_comb begin
    w_sel     = w_rr_grant;
    w_upd_ptr = 1'b1;
`ifdef CDB_PRIO0_EN
    if (req_valid[0]) begin
      w_sel     = '0;
      w_sel[0]  = 1'b1;
      w_upd_ptr = 1'b0;
    end
`endif
  end

  assign w_grant = w_block ? '0 : w_sel;
  assign w_any   = |w_grant;

  // Encode the winner index and pick its tag.
  always_comb begin
    w_win     = '0;
    w_win_tag = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_win     = 3'(i);
        w_win_tag = req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  assign w_next_ptr = (w_win == LAST_IDX) ? 3'd0 : (w_win + 3'd1);

  // Broadcast register and round-robin pointer; tag/src hold when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bcast_valid <= 1'b0;
      r_bcast_tag   <= '0;
      r_bcast_src   <= '0;
      r_rr_ptr      <= '0;
    end else begin
      r_bcast_valid <= w_any;
      if (w_any) begin
        r_bcast_tag <= w_win_tag;
        r_bcast_src <= w_win;
        if (w_upd_ptr) begin
          r_rr_ptr <= w_next_ptr;
        end
      end
    end
  end

  assign grant           = w_grant;
  assign broadcast_valid = r_bcast_valid;
  assign broadcast_tag   = r_bcast_tag;
  assign broadcast_src   = r_bcast_src;
  assign rr_ptr          = r_rr_ptr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed test of cdb_arbiter with NUM_REQ=4, TAG_W=6.
//   Inputs change 1 time unit after each rising edge; the combinational
//   grant and the registered outputs are sampled in that same window.
module tb_cdb_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 6;

  logic                     clk;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic                     cdb_stall;
  logic                     flush;
  logic [NUM_REQ-1:0]       grant;
  logic                     broadcast_valid;
  logic [TAG_W-1:0]         broadcast_tag;
  logic [2:0]               broadcast_src;
  logic [2:0]               rr_ptr;

  int n_asserts = 0;
  int n_fail    = 0;

  cdb_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_tag        (req_tag),
    .cdb_stall      (cdb_stall),
    .flush          (flush),
    .grant          (grant),
    .broadcast_valid(broadcast_valid),
    .broadcast_tag  (broadcast_tag),
    .broadcast_src  (broadcast_src),
    .rr_ptr         (rr_ptr)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_tag(input int unit, input logic [TAG_W-1:0] t);
    req_tag[unit*TAG_W +: TAG_W] = t;
  endtask

  logic [TAG_W-1:0]   exp_tag_seq [5] = '{6'd5, 6'd9, 6'd17, 6'd33, 6'd5};
  logic [2:0]         exp_ptr_seq [5] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
  logic [NUM_REQ-1:0] exp_gnt_seq [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

  initial begin
    // Reset held with every unit requesting.
    reset     = 1'b0;
    cdb_stall = 1'b0;
    flush     = 1'b0;
    req_valid = 4'b1111;
    req_tag   = '0;
    set_tag(0, 6'd5);
    set_tag(1, 6'd9);
    set_tag(2, 6'd17);
    set_tag(3, 6'd33);
    tick();
    tick();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_bvalid", 32'(broadcast_valid), 32'h0);
    chk("rst_rr_ptr", 32'(rr_ptr), 32'h0);
    chk("rst_btag", 32'(broadcast_tag), 32'h0);
    chk("rst_bsrc", 32'(broadcast_src), 32'h0);

    // Release: unit 0 wins first, then fair rotation with wrap.
    reset = 1'b1;
    #1;
    chk("first_grant", 32'(grant), 32'b0001);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("rr_bvalid_%0d", c), 32'(broadcast_valid), 32'h1);
      chk($sformatf("rr_btag_%0d", c), 32'(broadcast_tag), 32'(exp_tag_seq[c]));
      chk($sformatf("rr_ptr_%0d", c), 32'(rr_ptr), 32'(exp_ptr_seq[c]));
      chk($sformatf("rr_grant_%0d", c), 32'(grant), 32'(exp_gnt_seq[c]));
    end
    chk("rr_bsrc_last", 32'(broadcast_src), 32'd0);

    // Single requester, back-to-back: unit 2 with tags 12 then 13.
    req_valid = 4'b0100;
    set_tag(2, 6'd12);
    #1;
    chk("b2b_grant0", 32'(grant), 32'b0100);
    tick();
    chk("b2b_bvalid0", 32'(broadcast_valid), 32'h1);
    chk("b2b_btag0", 32'(broadcast_tag), 32'd12);
    chk("b2b_bsrc0", 32'(broadcast_src), 32'd2);
    chk("b2b_ptr0", 32'(rr_ptr), 32'd3);
    set_tag(2, 6'd13);
    #1;
    chk("b2b_grant1", 32'(grant), 32'b0100);
    tick();
    chk("b2b_bvalid1", 32'(broadcast_valid), 32'h1);
    chk("b2b_btag1", 32'(broadcast_tag), 32'd13);
    req_valid = 4'b0000;
    #1;
    chk("idle_grant", 32'(grant), 32'h0);
    tick();
    chk("idle_bvalid", 32'(broadcast_valid), 32'h0);
    chk("idle_btag_hold", 32'(broadcast_tag), 32'd13);
    chk("idle_bsrc_hold", 32'(broadcast_src), 32'd2);

    // Grant unit 3 (wrap) to bring rr_ptr back to 0.
    req_valid = 4'b1000;
    tick();
    chk("wrap_ptr", 32'(rr_ptr), 32'd0);
    chk("wrap_btag", 32'(broadcast_tag), 32'd33);
    chk("wrap_bsrc", 32'(broadcast_src), 32'd3);

    // Stall for 3 cycles with units 1 and 2 pending.
    req_valid = 4'b0110;
    cdb_stall = 1'b1;
    #1;
    chk("stall_grant_pre", 32'(grant), 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("stall_grant_%0d", c), 32'(grant), 32'h0);
      chk($sformatf("stall_bvalid_%0d", c), 32'(broadcast_valid), 32'h0);
      chk($sformatf("stall_ptr_%0d", c), 32'(rr_ptr), 32'd0);
    end
    cdb_stall = 1'b0;
    #1;
    chk("unstall_grant", 32'(grant), 32'b0010);
    tick();
    chk("unstall_btag", 32'(broadcast_tag), 32'd9);
    chk("unstall_ptr", 32'(rr_ptr), 32'd2);

    // Flush on the cycle unit 3 would be granted with tag 40.
    req_valid = 4'b1000;
    set_tag(3, 6'd40);
    flush = 1'b1;
    #1;
    chk("flush_grant", 32'(grant), 32'h0);
    tick();
    chk("flush_bvalid", 32'(broadcast_valid), 32'h0);
    chk("flush_ptr", 32'(rr_ptr), 32'd2);
    chk("flush_btag_hold", 32'(broadcast_tag), 32'd9);

    // Stall and flush together behave as flush.
    cdb_stall = 1'b1;
    #1;
    chk("flush_stall_grant", 32'(grant), 32'h0);
    tick();
    chk("flush_stall_bvalid", 32'(broadcast_valid), 32'h0);
    cdb_stall = 1'b0;
    flush     = 1'b0;
    #1;
    chk("post_flush_grant", 32'(grant), 32'b1000);
    tick();
    chk("post_flush_bvalid", 32'(broadcast_valid), 32'h1);
    chk("post_flush_btag", 32'(broadcast_tag), 32'd40);
    chk("post_flush_ptr", 32'(rr_ptr), 32'd0);

    // Mid-run asynchronous reset clears outputs without waiting for a clock.
    req_valid = 4'b1111;
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_bvalid", 32'(broadcast_valid), 32'h0);
    chk("async_rst_ptr", 32'(rr_ptr), 32'd0);
    chk("async_rst_btag", 32'(broadcast_tag), 32'd0);
    chk("async_rst_grant", 32'(grant), 32'h0);
    tick();
    reset = 1'b1;
    #1;
    chk("rerelease_grant", 32'(grant), 32'b0001);

`ifdef CDB_PRIO0_EN
    // Unit 0 has strict priority and leaves rr_ptr alone.
    req_valid = 4'b1011;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("prio_grant_%0d", c), 32'(grant), 32'b0001);
      tick();
      chk($sformatf("prio_ptr_%0d", c), 32'(rr_ptr), 32'd0);
    end
    req_valid = 4'b1010;
    #1;
    chk("prio_drop_grant1", 32'(grant), 32'b0010);
    tick();
    #1;
    chk("prio_drop_grant3", 32'(grant), 32'b1000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
